// File: rtl/fas_frame_sched.sv
// -----------------------------------------------------------------------------
// fas_frame_sched
//
// Frame scheduler between the FIR output stream and the 16-point FFT core.
// FIR samples are collected into a two-bank ping-pong buffer (N samples per
// bank). Each full bank is handed to the FFT core, and every completed FFT frame
// produces one analysis trigger. After FRAMES frames `done` is raised and held
// until reset.
//
// Optional feature macro: FAS_SCHED_OVF_EN
//   defined   : a dropped sample sets the sticky `overflow` flag
//   undefined : samples are still dropped, `overflow` is tied to 0
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   fir_valid    in   FIR sample strobe
//   fir_d        in   FIR sample (DW bits)
//   fft_start    out  one-cycle pulse: bank `fft_bank` is ready for the FFT
//   fft_bank     out  bank currently owned by the FFT core
//   fft_rd_addr  in   FFT read index within `fft_bank`
//   fft_rd_data  out  registered read data (one cycle latency)
//   fft_done     in   one-cycle pulse: FFT core has finished with `fft_bank`
//   ana_start    out  one-cycle pulse per completed frame
//   frame_cnt    out  number of completed frames
//   overflow     out  sticky sample-drop flag
//   done         out  all frames complete, held until reset
// -----------------------------------------------------------------------------
module fas_frame_sched #(
    parameter  int DW     = 16,
    parameter  int N      = 16,
    parameter  int FRAMES = 64,
    localparam int AW     = $clog2(N),
    localparam int CW     = $clog2(FRAMES) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic [DW-1:0] fir_d,
    output logic          fft_start,
    output logic          fft_bank,
    input  logic [AW-1:0] fft_rd_addr,
    output logic [DW-1:0] fft_rd_data,
    input  logic          fft_done,
    output logic          ana_start,
    output logic [CW-1:0] frame_cnt,
    output logic          overflow,
    output logic          done
);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILL,
        B_FULL,
        B_BUSY
    } bank_st_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } disp_st_e;

    // Sample storage: bank index in the MSB, sample index below it.
    logic [DW-1:0] mem [2*N];

    disp_st_e      state_q, state_d;
    bank_st_e      bank_st_q [2];
    bank_st_e      bank_st_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wp_q, wp_d;
    logic          fft_bank_q, fft_bank_d;
    logic          fft_start_q, fft_start_d;
    logic          ana_start_q, ana_start_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          done_q, done_d;
    logic [DW-1:0] fft_rd_data_q, fft_rd_data_d;

    logic          wr_en;
    logic          drop;
    logic          wr_open;

    // -------------------------------------------------------------------------
    // Next-state logic: write side and dispatch FSM
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        bank_st_d     = bank_st_q;
        wr_bank_d     = wr_bank_q;
        wp_d          = wp_q;
        fft_bank_d    = fft_bank_q;
        fft_start_d   = 1'b0;
        ana_start_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        done_d        = done_q;
        wr_en         = 1'b0;
        drop          = 1'b0;
        fft_rd_data_d = mem[{fft_bank_q, fft_rd_addr}];

        wr_open = (bank_st_q[wr_bank_q] == B_EMPTY) || (bank_st_q[wr_bank_q] == B_FILL);

        // Once all frames are done the input stream is ignored entirely,
        // including the drop detection.
        if (fir_valid && !done_q) begin
            if (wr_open) begin
                wr_en = 1'b1;
                if (wp_q == AW'(N - 1)) begin
                    bank_st_d[wr_bank_q] = B_FULL;
                    wp_d                 = '0;
                    wr_bank_d            = ~wr_bank_q;
                end else begin
                    bank_st_d[wr_bank_q] = B_FILL;
                    wp_d                 = wp_q + 1'b1;
                end
            end else begin
                // Bank still full or in use by the FFT: sample is lost and the
                // pointer stays put.
                drop = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // Banks fill strictly alternately, so when both are FULL the
                // one the write pointer has wrapped back to was filled first.
                if (!done_q) begin
                    if (bank_st_q[wr_bank_q] == B_FULL) begin
                        bank_st_d[wr_bank_q] = B_BUSY;
                        fft_bank_d           = wr_bank_q;
                        fft_start_d          = 1'b1;
                        state_d              = S_RUN;
                    end else if (bank_st_q[~wr_bank_q] == B_FULL) begin
                        bank_st_d[~wr_bank_q] = B_BUSY;
                        fft_bank_d            = ~wr_bank_q;
                        fft_start_d           = 1'b1;
                        state_d               = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // The busy bank is never the write target, so freeing it here
                // cannot collide with a write completing on the same edge.
                if (fft_done) begin
                    bank_st_d[fft_bank_q] = B_EMPTY;
                    ana_start_d           = 1'b1;
                    frame_cnt_d           = frame_cnt_q + 1'b1;
                    state_d               = S_IDLE;
                    if (frame_cnt_d == CW'(FRAMES)) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            bank_st_q[0]  <= B_EMPTY;
            bank_st_q[1]  <= B_EMPTY;
            wr_bank_q     <= 1'b0;
            wp_q          <= '0;
            fft_bank_q    <= 1'b0;
            fft_start_q   <= 1'b0;
            ana_start_q   <= 1'b0;
            frame_cnt_q   <= '0;
            done_q        <= 1'b0;
            fft_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            bank_st_q     <= bank_st_d;
            wr_bank_q     <= wr_bank_d;
            wp_q          <= wp_d;
            fft_bank_q    <= fft_bank_d;
            fft_start_q   <= fft_start_d;
            ana_start_q   <= ana_start_d;
            frame_cnt_q   <= frame_cnt_d;
            done_q        <= done_d;
            fft_rd_data_q <= fft_rd_data_d;
        end
    end

    // NOTE: the sample buffer has no reset; bank states alone decide what is
    // valid, so clearing the storage would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wp_q}] <= fir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Overflow flag
    // -------------------------------------------------------------------------
`ifdef FAS_SCHED_OVF_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    // Drops happen silently in this build.
    logic drop_unused;
    assign drop_unused = drop;
    assign overflow    = 1'b0;
`endif

    assign fft_start   = fft_start_q;
    assign fft_bank    = fft_bank_q;
    assign fft_rd_data = fft_rd_data_q;
    assign ana_start   = ana_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fas_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_fas_frame_sched
//
// Self-checking bench for fas_frame_sched. Accepted samples and the bank each
// completed fill should land in are pushed to queues as stimulus is driven; a
// small FFT-core model pops them when the DUT issues fft_start, reads the bank
// back and returns fft_done after a programmable hold time. A monitor tracks
// ana_start / frame_cnt / done.
// -----------------------------------------------------------------------------
module tb_fas_frame_sched;

    localparam int DW     = 16;
    localparam int N      = 16;
    localparam int FRAMES = 64;
    localparam int AW     = $clog2(N);
    localparam int CW     = $clog2(FRAMES) + 1;

`ifdef FAS_SCHED_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fir_valid = 1'b0;
    logic [DW-1:0] fir_d = '0;
    logic          fft_start;
    logic          fft_bank;
    logic [AW-1:0] fft_rd_addr = '0;
    logic [DW-1:0] fft_rd_data;
    logic          fft_done = 1'b0;
    logic          ana_start;
    logic [CW-1:0] frame_cnt;
    logic          overflow;
    logic          done;

    fas_frame_sched #(
        .DW     (DW),
        .N      (N),
        .FRAMES (FRAMES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fir_valid   (fir_valid),
        .fir_d       (fir_d),
        .fft_start   (fft_start),
        .fft_bank    (fft_bank),
        .fft_rd_addr (fft_rd_addr),
        .fft_rd_data (fft_rd_data),
        .fft_done    (fft_done),
        .ana_start   (ana_start),
        .frame_cnt   (frame_cnt),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Scoreboard queues and reference state
    logic [DW-1:0] data_q [$];
    logic          bank_q [$];
    logic          exp_wr_bank = 1'b0;
    int            exp_wp = 0;
    int            exp_frames = 0;
    bit            in_run = 1'b0;
    int            fft_hold = 39;
    bit            spur_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one sample for one cycle; accepted samples go to the scoreboard.
    task automatic send(input logic [DW-1:0] d, input bit dropped);
        @(posedge clk);
        #1;
        fir_valid = 1'b1;
        fir_d     = d;
        if (!dropped) begin
            data_q.push_back(d);
            if (exp_wp == N - 1) begin
                bank_q.push_back(exp_wr_bank);
                exp_wr_bank = ~exp_wr_bank;
                exp_wp      = 0;
            end else begin
                exp_wp++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            fir_valid = 1'b0;
        end
    endtask

    // Assert reset between clock edges and confirm the outputs clear at once.
    task automatic do_reset;
        @(negedge clk);
        #2;
        rst       = 1'b0;
        fir_valid = 1'b0;
        spur_req  = 1'b0;
        #1;
        check("rst_fft_start",   fft_start,   0);
        check("rst_fft_bank",    fft_bank,    0);
        check("rst_fft_rd_data", fft_rd_data, 0);
        check("rst_ana_start",   ana_start,   0);
        check("rst_frame_cnt",   frame_cnt,   0);
        check("rst_overflow",    overflow,    0);
        check("rst_done",        done,        0);
        data_q.delete();
        bank_q.delete();
        exp_wr_bank = 1'b0;
        exp_wp      = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (exp_frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_reached", exp_frames, n);
    endtask

    // FFT-core model: serve one dispatched bank.
    task automatic serve_frame;
        int            hold;
        int            popped;
        bit            aborted;
        logic          exp_b;
        logic [DW-1:0] exp_d;
        hold    = fft_hold;
        popped  = 0;
        aborted = 1'b0;
        if (bank_q.size() == 0) begin
            check("unexpected_fft_start", bank_q.size(), 1);
        end else begin
            exp_b = bank_q.pop_front();
            check("fft_bank", fft_bank, exp_b);
        end
        for (int i = 0; i < hold && !aborted; i++) begin
            @(posedge clk);
            #1;
            if (!rst) begin
                aborted = 1'b1;
            end else begin
                if (i < N) fft_rd_addr = AW'(i);
                @(negedge clk);
                if (!rst) begin
                    aborted = 1'b1;
                end else if (i >= 1 && i <= N) begin
                    if (data_q.size() == 0) begin
                        check("data_q_underflow", data_q.size(), 1);
                    end else begin
                        exp_d = data_q.pop_front();
                        check("fft_rd_data", fft_rd_data, exp_d);
                        popped++;
                    end
                end
            end
        end
        if (!aborted) begin
            // Short holds finish before the whole bank is read back.
            while (popped < N && data_q.size() > 0) begin
                exp_d = data_q.pop_front();
                popped++;
            end
            @(posedge clk);
            #1;
            fft_done = 1'b1;
            @(posedge clk);
            #1;
            fft_done = 1'b0;
        end
    endtask

    initial begin : fft_model
        forever begin
            @(negedge clk);
            if (!rst) begin
                fft_done = 1'b0;
            end else if (spur_req) begin
                spur_req = 1'b0;
                @(posedge clk);
                #1;
                fft_done = 1'b1;
                @(posedge clk);
                #1;
                fft_done = 1'b0;
            end else if (fft_start) begin
                serve_frame();
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_frames = 0;
                in_run     = 1'b0;
            end else begin
                if (ana_start) begin
                    check("ana_without_run", in_run, 1);
                    in_run = 1'b0;
                    exp_frames++;
                    check("frame_cnt", frame_cnt, exp_frames);
                    check("done_at_pulse", done, exp_frames == FRAMES);
                end
                if (fft_start) begin
                    check("start_during_run", in_run, 0);
                    in_run = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Single frame, exact dispatch timing, read-back through the model
        do_reset();
        fft_hold = 39;
        for (int i = 1; i <= N; i++) send(DW'(i), 1'b0);
        @(posedge clk);
        #1;
        fir_valid = 1'b0;
        @(negedge clk);
        check("t1_start_not_yet", fft_start, 0);
        @(negedge clk);
        check("t1_start", fft_start, 1);
        check("t1_bank", fft_bank, 0);
        wait_frames(1, 200);

        // Spurious fft_done while idle
        spur_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t6_no_ana", ana_start, 0);
        end
        check("t6_frame_cnt", frame_cnt, 1);

        // Full run of FRAMES frames, paced so no sample is dropped
        do_reset();
        fft_hold = 39;
        for (int i = 0; i < FRAMES * N; i++) begin
            send(DW'(i * 7 + 3), 1'b0);
            idle(2);
        end
        wait_frames(FRAMES, 400);
        check("t2_done", done, 1);
        check("t2_frame_cnt", frame_cnt, FRAMES);
        check("t2_overflow", overflow, 0);
        // After done, samples are ignored and never flagged
        for (int i = 0; i < 20; i++) send(16'hdead, 1'b1);
        idle(1);
        repeat (60) @(negedge clk);
        check("t2_done_held", done, 1);
        check("t2_cnt_held", frame_cnt, FRAMES);
        check("t2_no_ovf_after_done", overflow, 0);
        check("t2_no_extra_start", in_run, 0);

        // FFT holds bank 0 long enough for the 33rd sample to be dropped
        do_reset();
        fft_hold = 59;
        for (int i = 1; i <= 2 * N; i++) send(DW'(16'h3000 + i), 1'b0);
        send(16'h3fff, 1'b1);
        @(posedge clk);
        #1;
        fir_valid = 1'b0;
        @(negedge clk);
        check("t3_ovf_next", overflow, OVF_EXP);
        repeat (5) @(negedge clk);
        check("t3_ovf_sticky", overflow, OVF_EXP);
        wait_frames(2, 300);
        check("t3_ovf_hold", overflow, OVF_EXP);
        // Drop did not advance the pointer: next frame starts at address 0
        for (int i = 0; i < N; i++) send(DW'(16'h3100 + i), 1'b0);
        idle(1);
        wait_frames(3, 300);

        // fft_done on the same edge as the 16th write into bank 1
        do_reset();
        fft_hold = 13;
        for (int i = 1; i <= 2 * N; i++) begin
            send(DW'(16'h4000 + i), 1'b0);
            if (i == 24) fft_hold = 39;
        end
        @(posedge clk);
        #1;
        fir_valid = 1'b0;
        @(negedge clk);
        check("t4_ana", ana_start, 1);
        check("t4_start_not_yet", fft_start, 0);
        @(negedge clk);
        check("t4_start", fft_start, 1);
        check("t4_bank", fft_bank, 1);
        for (int i = 0; i < N; i++) send(DW'(16'h4100 + i), 1'b0);
        idle(1);
        wait_frames(3, 300);

        // Reset in the middle of frame 3
        do_reset();
        fft_hold = 39;
        for (int i = 0; i < 2 * N + 8; i++) begin
            send(DW'(16'h5000 + i), 1'b0);
            idle(2);
        end
        do_reset();
        for (int i = 0; i < N; i++) send(DW'(16'h6000 + i), 1'b0);
        idle(1);
        wait_frames(1, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
